// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM state
// encoding, ALU op-code constants and the operand width.
package alu_arbiter_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_t;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLLI = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_SRLI = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SRAI = 3'b101;
    localparam logic [2:0] ALU_AND  = 3'b111;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the requester/response handshakes and the shared-ALU bus.
// slave  : the arbiter side.
// master : the requesters plus the external ALU.
interface alu_arbiter_if;
    import alu_arbiter_pkg::*;

    logic            REQ0_VALID;
    logic            REQ1_VALID;
    logic            REQ0_READY;
    logic            REQ1_READY;
    logic [2:0]      REQ0_OP;
    logic [2:0]      REQ1_OP;
    logic            REQ0_JALR;
    logic            REQ1_JALR;
    logic [XLEN-1:0] REQ0_OP1;
    logic [XLEN-1:0] REQ0_OP2;
    logic [XLEN-1:0] REQ1_OP1;
    logic [XLEN-1:0] REQ1_OP2;
    logic            RSP0_VALID;
    logic            RSP1_VALID;
    logic            RSP0_READY;
    logic            RSP1_READY;
    logic [XLEN-1:0] RSP0_DATA;
    logic [XLEN-1:0] RSP1_DATA;
    logic [2:0]      ALU_OP;
    logic [XLEN-1:0] OP1;
    logic [XLEN-1:0] OP2;
    logic            JALR;
    logic [XLEN-1:0] ALU_Salida;
    logic [15:0]     OPS_DONE;

    modport slave (
        input  REQ0_VALID, REQ1_VALID, REQ0_OP, REQ1_OP, REQ0_JALR, REQ1_JALR,
               REQ0_OP1, REQ0_OP2, REQ1_OP1, REQ1_OP2, RSP0_READY, RSP1_READY,
               ALU_Salida,
        output REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP0_DATA,
               RSP1_DATA, ALU_OP, OP1, OP2, JALR, OPS_DONE
    );

    modport master (
        output REQ0_VALID, REQ1_VALID, REQ0_OP, REQ1_OP, REQ0_JALR, REQ1_JALR,
               REQ0_OP1, REQ0_OP2, REQ1_OP1, REQ1_OP2, RSP0_READY, RSP1_READY,
               ALU_Salida,
        input  REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP0_DATA,
               RSP1_DATA, ALU_OP, OP1, OP2, JALR, OPS_DONE
    );

endinterface

// File: rtl/alu_arbiter_rr_grant2.sv
// Two-way round-robin grant: a lone valid always wins, a tie goes to the
// requester named by the pointer.
module rr_grant2 (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_ptr,
    output logic o_gnt_idx,
    output logic o_gnt_valid
);

    // Pick the winner from the valid pattern and the pointer.
    always_comb begin
        o_gnt_idx   = 1'b0;
        o_gnt_valid = 1'b0;
        case ({i_valid1, i_valid0})
            2'b01: begin
                o_gnt_idx   = 1'b0;
                o_gnt_valid = 1'b1;
            end
            2'b10: begin
                o_gnt_idx   = 1'b1;
                o_gnt_valid = 1'b1;
            end
            2'b11: begin
                o_gnt_idx   = i_ptr;
                o_gnt_valid = 1'b1;
            end
            default: begin
                o_gnt_idx   = 1'b0;
                o_gnt_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU.
// One operation is in flight at a time: IDLE accepts, EXEC captures the
// ALU result, RESP holds the response until the owner consumes it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic           CLK,
    input  logic           RST_N,
    alu_arbiter_if.slave   bus
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_ptr;
    logic              r_gnt_idx;
    logic [2:0]        r_op;
    logic              r_jalr;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [DATA_W-1:0] r_result;
    logic [15:0]       r_ops_done;

    logic              w_gnt_idx;
    logic              w_gnt_valid;
    logic              w_accept;
    logic              w_rsp_ready;
    logic              w_in_resp;

    rr_grant2 u_rr_grant2 (
        .i_valid0    (bus.REQ0_VALID),
        .i_valid1    (bus.REQ1_VALID),
        .i_ptr       (r_ptr),
        .o_gnt_idx   (w_gnt_idx),
        .o_gnt_valid (w_gnt_valid)
    );

    // Next-state decode; accept only happens in IDLE with a pending request.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        if (r_gnt_idx) begin
            w_rsp_ready = bus.RSP1_READY;
        end else begin
            w_rsp_ready = bus.RSP0_READY;
        end
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (w_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register, payload latch, result capture and completion counter.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 1'b0;
            r_gnt_idx  <= 1'b0;
            r_op       <= 3'b000;
            r_jalr     <= 1'b0;
            r_op1      <= {DATA_W{1'b0}};
            r_op2      <= {DATA_W{1'b0}};
            r_result   <= {DATA_W{1'b0}};
            r_ops_done <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_gnt_idx <= w_gnt_idx;
                r_op      <= w_gnt_idx ? bus.REQ1_OP   : bus.REQ0_OP;
                r_jalr    <= w_gnt_idx ? bus.REQ1_JALR : bus.REQ0_JALR;
                r_op1     <= w_gnt_idx ? bus.REQ1_OP1  : bus.REQ0_OP1;
                r_op2     <= w_gnt_idx ? bus.REQ1_OP2  : bus.REQ0_OP2;
            end
            if (r_state == ST_EXEC) begin
                r_result <= bus.ALU_Salida;
            end
            if ((r_state == ST_RESP) && w_rsp_ready) begin
                r_ptr      <= ~r_gnt_idx;
                r_ops_done <= r_ops_done + 16'd1;
            end
        end
    end

    assign w_in_resp = (r_state == ST_RESP);

    assign bus.REQ0_READY = w_accept & ~w_gnt_idx;
    assign bus.REQ1_READY = w_accept &  w_gnt_idx;

    assign bus.RSP0_VALID = w_in_resp & ~r_gnt_idx;
    assign bus.RSP1_VALID = w_in_resp &  r_gnt_idx;
    assign bus.RSP0_DATA  = (w_in_resp && !r_gnt_idx) ? r_result : {DATA_W{1'b0}};
    assign bus.RSP1_DATA  = (w_in_resp &&  r_gnt_idx) ? r_result : {DATA_W{1'b0}};

    // The ALU always sees the latched operation so its inputs never glitch.
    assign bus.ALU_OP   = r_op;
    assign bus.OP1      = r_op1;
    assign bus.OP2      = r_op2;
    assign bus.JALR     = r_jalr;
    assign bus.OPS_DONE = r_ops_done;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the external ALU.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   both_cnt;
    logic [15:0] exp_ops;

    alu_arbiter_if bus ();

    alu_arbiter #(.DATA_W(32)) u_dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External ALU model.
    always_comb begin
        bus.ALU_Salida = 32'h0000_0000;
        case (bus.ALU_OP)
            ALU_ADD:  bus.ALU_Salida = bus.JALR ? ((bus.OP1 + bus.OP2) & 32'hFFFF_FFFE) : (bus.OP1 + bus.OP2);
            ALU_SLLI: bus.ALU_Salida = bus.OP1 << bus.OP2[4:0];
            ALU_SUB:  bus.ALU_Salida = bus.OP1 - bus.OP2;
            ALU_SRLI: bus.ALU_Salida = bus.OP1 >> bus.OP2[4:0];
            ALU_XOR:  bus.ALU_Salida = bus.OP1 ^ bus.OP2;
            ALU_SRAI: bus.ALU_Salida = $signed(bus.OP1) >>> bus.OP2[4:0];
            ALU_AND:  bus.ALU_Salida = bus.OP1 & bus.OP2;
            default:  bus.ALU_Salida = 32'h0000_0000;
        endcase
    end

    // Count any cycle where both requesters see READY together.
    always @(negedge clk) begin
        if (bus.REQ0_READY && bus.REQ1_READY) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [2:0] op, input logic jalr,
                           input logic [31:0] a, input logic [31:0] b);
        if (idx == 0) begin
            bus.REQ0_OP = op; bus.REQ0_JALR = jalr; bus.REQ0_OP1 = a; bus.REQ0_OP2 = b;
            bus.REQ0_VALID = 1'b1;
        end else begin
            bus.REQ1_OP = op; bus.REQ1_JALR = jalr; bus.REQ1_OP1 = a; bus.REQ1_OP2 = b;
            bus.REQ1_VALID = 1'b1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rdy0"},  32'(bus.REQ0_READY), 32'd0);
        check({tag, "_rdy1"},  32'(bus.REQ1_READY), 32'd0);
        check({tag, "_rv0"},   32'(bus.RSP0_VALID), 32'd0);
        check({tag, "_rv1"},   32'(bus.RSP1_VALID), 32'd0);
        check({tag, "_rd0"},   bus.RSP0_DATA,        32'd0);
        check({tag, "_rd1"},   bus.RSP1_DATA,        32'd0);
        check({tag, "_aluop"}, 32'(bus.ALU_OP),     32'd0);
        check({tag, "_op1"},   bus.OP1,              32'd0);
        check({tag, "_op2"},   bus.OP2,              32'd0);
        check({tag, "_jalr"},  32'(bus.JALR),       32'd0);
        check({tag, "_ops"},   32'(bus.OPS_DONE),   32'd0);
    endtask

    // Runs one operation from its accept cycle (called just before the
    // accepting edge) to completion with immediate response consumption.
    task automatic complete(input int idx, input logic [31:0] exp, input string tag);
        logic my_rdy, oth_rdy, my_rv, oth_rv;
        logic [31:0] my_rd, oth_rd;
        my_rdy  = (idx == 0) ? bus.REQ0_READY : bus.REQ1_READY;
        oth_rdy = (idx == 0) ? bus.REQ1_READY : bus.REQ0_READY;
        check({tag, "_ready"},      32'(my_rdy),  32'd1);
        check({tag, "_other_rdy"},  32'(oth_rdy), 32'd0);
        @(posedge clk); @(negedge clk);
        if (idx == 0) bus.REQ0_VALID = 1'b0; else bus.REQ1_VALID = 1'b0;
        #1;
        my_rv = (idx == 0) ? bus.RSP0_VALID : bus.RSP1_VALID;
        check({tag, "_exec_rv"},   32'(my_rv), 32'd0);
        check({tag, "_exec_rdy"},  32'(bus.REQ0_READY | bus.REQ1_READY), 32'd0);
        @(posedge clk); @(negedge clk);
        my_rv  = (idx == 0) ? bus.RSP0_VALID : bus.RSP1_VALID;
        oth_rv = (idx == 0) ? bus.RSP1_VALID : bus.RSP0_VALID;
        my_rd  = (idx == 0) ? bus.RSP0_DATA  : bus.RSP1_DATA;
        oth_rd = (idx == 0) ? bus.RSP1_DATA  : bus.RSP0_DATA;
        check({tag, "_rv"},        32'(my_rv),  32'd1);
        check({tag, "_data"},      my_rd,        exp);
        check({tag, "_other_rv"},  32'(oth_rv), 32'd0);
        check({tag, "_other_rd"},  oth_rd,       32'd0);
        if (idx == 0) bus.RSP0_READY = 1'b1; else bus.RSP1_READY = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.RSP0_READY = 1'b0;
        bus.RSP1_READY = 1'b0;
        exp_ops = exp_ops + 16'd1;
        #1;
        my_rv = (idx == 0) ? bus.RSP0_VALID : bus.RSP1_VALID;
        check({tag, "_ops"},       32'(bus.OPS_DONE), 32'(exp_ops));
        check({tag, "_done_rv"},   32'(my_rv), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.REQ0_VALID = 1'b0; bus.REQ1_VALID = 1'b0;
        bus.RSP0_READY = 1'b0; bus.RSP1_READY = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_ops = 16'h0000;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; both_cnt = 0; exp_ops = 16'h0000;
        rst_n = 1'b0;
        bus.REQ0_VALID = 1'b0; bus.REQ1_VALID = 1'b0;
        bus.REQ0_OP = 3'b000; bus.REQ1_OP = 3'b000;
        bus.REQ0_JALR = 1'b0; bus.REQ1_JALR = 1'b0;
        bus.REQ0_OP1 = 32'd0; bus.REQ0_OP2 = 32'd0;
        bus.REQ1_OP1 = 32'd0; bus.REQ1_OP2 = 32'd0;
        bus.RSP0_READY = 1'b0; bus.RSP1_READY = 1'b0;

        // Reset state
        do_reset();
        #1;
        check_zero("rst");

        // REQ0 ADD 5+7
        @(negedge clk); set_req(0, ALU_ADD, 1'b0, 32'd5, 32'd7); #1;
        complete(0, 32'd12, "add0");

        // REQ1 ADD with JALR, SRAI, SUB
        @(negedge clk); set_req(1, ALU_ADD, 1'b1, 32'h0000_1001, 32'h0000_0004); #1;
        complete(1, 32'h0000_1004, "jalr1");
        @(negedge clk); set_req(1, ALU_SRAI, 1'b0, 32'h8000_0000, 32'd4); #1;
        complete(1, 32'hF800_0000, "srai1");
        @(negedge clk); set_req(1, ALU_SUB, 1'b0, 32'd3, 32'd5); #1;
        complete(1, 32'hFFFF_FFFE, "sub1");

        // Unsupported op code returns 0
        @(negedge clk); set_req(0, 3'b110, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0); #1;
        check("unsup_aluop_pre", 32'(bus.ALU_OP), 32'(ALU_SUB));
        complete(0, 32'h0000_0000, "unsup0");
        check("unsup_aluop_fwd", 32'(bus.ALU_OP), 32'd6);

        // Round-robin after reset: REQ0, REQ1, then REQ0 first again
        do_reset();
        set_req(0, ALU_SUB, 1'b0, 32'd100, 32'd1);
        set_req(1, ALU_XOR, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        #1;
        complete(0, 32'd99, "rr_a0");
        complete(1, 32'hFF00_FF00, "rr_a1");
        @(negedge clk);
        set_req(0, ALU_AND, 1'b0, 32'hFFFF_0000, 32'h1234_5678);
        set_req(1, ALU_SRLI, 1'b0, 32'h8000_0000, 32'd4);
        #1;
        complete(0, 32'h1234_0000, "rr_b0");
        complete(1, 32'h0800_0000, "rr_b1");

        // Backpressure on RSP0 while REQ1 waits
        @(negedge clk); set_req(0, ALU_ADD, 1'b0, 32'h7FFF_FFFF, 32'd1); #1;
        check("bp_rdy0", 32'(bus.REQ0_READY), 32'd1);
        @(posedge clk); @(negedge clk);
        bus.REQ0_VALID = 1'b0;
        set_req(1, ALU_SLLI, 1'b0, 32'd3, 32'd4);
        #1;
        check("bp_exec_rdy1", 32'(bus.REQ1_READY), 32'd0);
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("bp_rv0",   32'(bus.RSP0_VALID), 32'd1);
            check("bp_rd0",   bus.RSP0_DATA,        32'h8000_0000);
            check("bp_rdy1",  32'(bus.REQ1_READY), 32'd0);
            @(posedge clk); @(negedge clk);
        end
        bus.RSP0_READY = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.RSP0_READY = 1'b0;
        exp_ops = exp_ops + 16'd1;
        #1;
        check("bp_ops",     32'(bus.OPS_DONE),   32'(exp_ops));
        check("bp_rv0_off", 32'(bus.RSP0_VALID), 32'd0);
        complete(1, 32'h0000_0030, "bp_req1");

        // Reset while in EXEC discards the operation
        @(negedge clk); set_req(0, ALU_ADD, 1'b0, 32'd5, 32'd7); #1;
        @(posedge clk); @(negedge clk);
        bus.REQ0_VALID = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        exp_ops = 16'h0000;
        #1;
        check_zero("rexec");
        @(posedge clk); @(negedge clk);
        check("rexec_rv0", 32'(bus.RSP0_VALID), 32'd0);
        check("rexec_rv1", 32'(bus.RSP1_VALID), 32'd0);
        set_req(0, ALU_SLLI, 1'b0, 32'd1, 32'd3); #1;
        complete(0, 32'd8, "rexec_next");

        // Completion counter wrap from a preset value
        @(negedge clk);
        force u_dut.r_ops_done = 16'hFFFE;
        #1;
        release u_dut.r_ops_done;
        exp_ops = 16'hFFFE;
        @(negedge clk); set_req(1, ALU_XOR, 1'b0, 32'hAAAA_5555, 32'hFFFF_FFFF); #1;
        complete(1, 32'h5555_AAAA, "wrap_a");
        @(negedge clk); set_req(0, ALU_ADD, 1'b0, 32'd1, 32'd1); #1;
        complete(0, 32'd2, "wrap_b");
        check("ops_wrap", 32'(bus.OPS_DONE), 32'h0000_0000);

        check("both_ready_cycles", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
